// File: rtl/change_dispenser.sv
// change_dispenser: takes a change amount and ejects it one coin at a time,
// largest coin first. Each coin waits for coin_ack, bounded by a timeout.
// Tracks the stock of both coins and reports done, shortfall and error.
module change_dispenser #(
  parameter int unsigned AMOUNT_W      = 5,
  parameter int unsigned COIN_HI       = 10,
  parameter int unsigned COIN_LO       = 5,
  parameter int unsigned STOCK_W       = 4,
  parameter int unsigned INIT_STOCK_HI = 8,
  parameter int unsigned INIT_STOCK_LO = 8,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dispense_start_i,
  input  logic [AMOUNT_W-1:0] change_amount_i,
  input  logic                refill_i,
  input  logic                coin_ack_i,
  output logic                eject_hi_o,
  output logic                eject_lo_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [AMOUNT_W-1:0] shortfall_o,
  output logic                error_o,
  output logic [STOCK_W-1:0]  stock_hi_o,
  output logic [STOCK_W-1:0]  stock_lo_o
);

  // Counter only has to reach TIMEOUT-1; the timeout fires on that cycle.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [AMOUNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                eject_hi_q, eject_hi_d;
  logic                eject_lo_q, eject_lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [AMOUNT_W-1:0] shortfall_q, shortfall_d;
  logic                error_q, error_d;
  logic [STOCK_W-1:0]  stock_hi_q, stock_hi_d;
  logic [STOCK_W-1:0]  stock_lo_q, stock_lo_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    eject_hi_d  = eject_hi_q;
    eject_lo_d  = eject_lo_q;
    done_d      = 1'b0;
    shortfall_d = shortfall_q;
    error_d     = error_q;
    stock_hi_d  = stock_hi_q;
    stock_lo_d  = stock_lo_q;

    unique case (state_q)
      IDLE: begin
        if (refill_i) begin
          stock_hi_d = STOCK_W'(INIT_STOCK_HI);
          stock_lo_d = STOCK_W'(INIT_STOCK_LO);
        end
        if (dispense_start_i) begin
          rem_d       = change_amount_i;
          shortfall_d = '0;
          error_d     = 1'b0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (rem_q >= AMOUNT_W'(COIN_HI) && stock_hi_q != '0) begin
          eject_hi_d = 1'b1;
          cnt_d      = '0;
          state_d    = EJECT;
        end else if (rem_q >= AMOUNT_W'(COIN_LO) && stock_lo_q != '0) begin
          eject_lo_d = 1'b1;
          cnt_d      = '0;
          state_d    = EJECT;
        end else begin
          shortfall_d = rem_q;
          error_d     = (rem_q != '0);
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      EJECT: begin
        if (coin_ack_i) begin
          if (eject_hi_q) begin
            rem_d      = rem_q - AMOUNT_W'(COIN_HI);
            stock_hi_d = stock_hi_q - STOCK_W'(1);
          end else begin
            rem_d      = rem_q - AMOUNT_W'(COIN_LO);
            stock_lo_d = stock_lo_q - STOCK_W'(1);
          end
          eject_hi_d = 1'b0;
          eject_lo_d = 1'b0;
          state_d    = SELECT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Unacknowledged coin is not deducted from the amount.
          eject_hi_d  = 1'b0;
          eject_lo_d  = 1'b0;
          shortfall_d = rem_q;
          error_d     = 1'b1;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      eject_hi_q  <= 1'b0;
      eject_lo_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shortfall_q <= '0;
      error_q     <= 1'b0;
      stock_hi_q  <= STOCK_W'(INIT_STOCK_HI);
      stock_lo_q  <= STOCK_W'(INIT_STOCK_LO);
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      eject_hi_q  <= eject_hi_d;
      eject_lo_q  <= eject_lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shortfall_q <= shortfall_d;
      error_q     <= error_d;
      stock_hi_q  <= stock_hi_d;
      stock_lo_q  <= stock_lo_d;
    end
  end

  assign eject_hi_o  = eject_hi_q;
  assign eject_lo_o  = eject_lo_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign shortfall_o = shortfall_q;
  assign error_o     = error_q;
  assign stock_hi_o  = stock_hi_q;
  assign stock_lo_o  = stock_lo_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

  localparam int unsigned AMOUNT_W = 5;
  localparam int unsigned STOCK_W  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                dispense_start;
  logic [AMOUNT_W-1:0] change_amount;
  logic                refill;
  logic                coin_ack;
  logic                eject_hi, eject_lo, busy, done, error;
  logic [AMOUNT_W-1:0] shortfall;
  logic [STOCK_W-1:0]  stock_hi, stock_lo;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-transaction observations.
  int seq;        // coin order, base 3: hi=2, lo=1
  int done_cyc;   // cycles from start to done
  int first_ej;   // cycles from start to first eject
  int hi_cycles;  // cycles eject_hi was high

  change_dispenser dut (
    .clk              (clk),
    .reset            (reset),
    .dispense_start_i (dispense_start),
    .change_amount_i  (change_amount),
    .refill_i         (refill),
    .coin_ack_i       (coin_ack),
    .eject_hi_o       (eject_hi),
    .eject_lo_o       (eject_lo),
    .busy_o           (busy),
    .done_o           (done),
    .shortfall_o      (shortfall),
    .error_o          (error),
    .stock_hi_o       (stock_hi),
    .stock_lo_o       (stock_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic run(input int amt, input bit ack_en, input bit refill_start,
                     input bit refill_busy, input bit restart_busy);
    bit prev_ej;
    bit ej;
    tick();
    dispense_start = 1'b1;
    change_amount  = AMOUNT_W'(amt);
    refill         = refill_start;
    tick();
    dispense_start = 1'b0;
    refill         = refill_busy;
    seq = 0; done_cyc = -1; first_ej = -1; hi_cycles = 0; prev_ej = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (cyc == 1 && restart_busy) begin
        dispense_start = 1'b1;
        change_amount  = AMOUNT_W'(25);
      end else begin
        dispense_start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      ej = eject_hi | eject_lo;
      if (ej && !prev_ej) begin
        seq = seq * 3 + (eject_hi ? 2 : 1);
        if (first_ej < 0) first_ej = cyc;
      end
      if (eject_hi) hi_cycles++;
      prev_ej  = ej;
      coin_ack = ack_en && ej;
      tick();
    end
    coin_ack = 1'b0;
    refill   = 1'b0;
    dispense_start = 1'b0;
    check("done_seen", int'(done_cyc >= 0), 1);
  endtask

  // Done must be a single-cycle pulse and busy must drop afterwards.
  task automatic check_after(input string tag);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int n_done;
    int n_ej;
    reset = 1'b1; dispense_start = 1'b0; change_amount = '0;
    refill = 1'b0; coin_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_eject",     int'(eject_hi | eject_lo), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_error",     int'(error), 0);
    check("rst_stock_hi",  int'(stock_hi), 8);
    check("rst_stock_lo",  int'(stock_lo), 8);

    // 15 -> one hi then one lo
    run(15, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_seq",       seq, 7);
    check("t1_first_ej",  first_ej, 2);
    check("t1_done_cyc",  done_cyc, 6);
    check("t1_shortfall", int'(shortfall), 0);
    check("t1_error",     int'(error), 0);
    check("t1_stock_hi",  int'(stock_hi), 7);
    check("t1_stock_lo",  int'(stock_lo), 7);
    check_after("t1");

    // Refill together with start: reloads to 8/8, then 30 -> hi x3
    run(30, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2a_seq",      seq, 26);
    check("t2a_stock_hi", int'(stock_hi), 5);
    check("t2a_stock_lo", int'(stock_lo), 8);
    run(30, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2b_stock_hi", int'(stock_hi), 2);
    run(10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2c_stock_hi", int'(stock_hi), 1);
    // Only one hi coin left: 20 -> hi, lo, lo
    run(20, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_seq",       seq, 22);
    check("t2_shortfall", int'(shortfall), 0);
    check("t2_error",     int'(error), 0);
    check("t2_stock_hi",  int'(stock_hi), 0);
    check("t2_stock_lo",  int'(stock_lo), 6);

    // 7 -> one lo, residue 2; refill held while busy must be ignored
    run(7, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3a_seq",       seq, 1);
    check("t3a_shortfall", int'(shortfall), 2);
    check("t3a_error",     int'(error), 1);
    check("t3a_stock_hi",  int'(stock_hi), 0);
    check("t3a_stock_lo",  int'(stock_lo), 5);
    run(3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3b_seq",       seq, 0);
    check("t3b_shortfall", int'(shortfall), 3);
    check("t3b_error",     int'(error), 1);
    check_after("t3b");
    check("t3b_held_short", int'(shortfall), 3);

    // Stand-alone refill in IDLE
    refill = 1'b1;
    tick();
    refill = 1'b0;
    tick();
    check("refill_hi", int'(stock_hi), 8);
    check("refill_lo", int'(stock_lo), 8);

    // Zero amount, stray ack held high throughout
    coin_ack = 1'b1;
    run(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_seq",       seq, 0);
    check("t4_done_cyc",  done_cyc, 2);
    check("t4_shortfall", int'(shortfall), 0);
    check("t4_error",     int'(error), 0);
    check_after("t4");
    check("t4_stock_hi",  int'(stock_hi), 8);

    // No ack: timeout after 16 cycles of eject_hi
    run(15, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_hi_cycles", hi_cycles, 16);
    check("t5_done_cyc",  done_cyc, 18);
    check("t5_shortfall", int'(shortfall), 15);
    check("t5_error",     int'(error), 1);
    check("t5_stock_hi",  int'(stock_hi), 8);
    check("t5_stock_lo",  int'(stock_lo), 8);
    check_after("t5");

    // Start while busy (amount 25) must not replace the 10 in progress
    run(10, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6a_seq",       seq, 2);
    check("t6a_shortfall", int'(shortfall), 0);
    check("t6a_stock_hi",  int'(stock_hi), 7);

    // Reset in EJECT abandons the transaction and restores stocks
    tick();
    dispense_start = 1'b1;
    change_amount  = AMOUNT_W'(15);
    tick();
    dispense_start = 1'b0;
    tick();
    check("t6b_eject_pre", int'(eject_hi), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6b_eject",    int'(eject_hi | eject_lo), 0);
    check("t6b_busy",     int'(busy), 0);
    check("t6b_done",     int'(done), 0);
    check("t6b_stock_hi", int'(stock_hi), 8);
    check("t6b_stock_lo", int'(stock_lo), 8);
    n_done = 0;
    n_ej   = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done) n_done++;
      if (eject_hi | eject_lo) n_ej++;
    end
    check("t6b_no_done",  n_done, 0);
    check("t6b_no_eject", n_ej, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
